// File: rtl/hue_calc.sv
// hue_calc: pipelined hue back-end for hsv_decoder.
// The input is magnitude(dividend)*60 / divisor. A 6-stage restoring divider
// produces a floor quotient. The quotient is then clamped and mapped to a
// hue angle in degrees.
// Timing: a pixel sampled at edge N appears on the outputs after edge N+8.
// Pipeline: stage 0, then divider stages 1..6, then stage 7
// (clamp/grey decision), then the output register.
module hue_calc #(
  parameter int HUE_W = 9
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [8:0]       i_dividend,
  input  logic [8:0]       i_divisor,
  input  logic [1:0]       i_function,
  input  logic             i_valid,
  output logic [HUE_W-1:0] o_hue,
  output logic             o_grey,
  output logic             o_valid
);

  // Per-stage pipeline state. Index 0 is the input register and index k is
  // divider stage k.
  logic [13:0] rem_reg   [0:6];
  logic [7:0]  div_reg   [0:6];
  logic [5:0]  q_reg     [0:6];
  logic        sign_reg  [0:6];
  logic [1:0]  func_reg  [0:6];
  logic        valid_reg [0:6];

  logic [7:0]  mag;
  logic [13:0] num;

  // Take |dividend| and scale it by 60 using shifts only: 64*m - 4*m.
  always_comb begin
    mag = i_dividend[8] ? 8'(-i_dividend) : i_dividend[7:0];
    num = {mag, 6'b0} - {4'b0, mag, 2'b0};
  end

  // Stage 0 registers the scaled numerator and the side-band fields.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      valid_reg[0] <= 1'b0;
      rem_reg[0]   <= '0;
      div_reg[0]   <= '0;
      q_reg[0]     <= '0;
      sign_reg[0]  <= 1'b0;
      func_reg[0]  <= '0;
    end else begin
      valid_reg[0] <= i_valid;
      if (i_valid) begin
        rem_reg[0]  <= num;
        div_reg[0]  <= i_divisor[7:0];
        q_reg[0]    <= '0;
        sign_reg[0] <= i_dividend[8];
        func_reg[0] <= i_function;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= 6; gi++) begin : div_stage
      localparam int SH = 6 - gi;
      logic [13:0] cmp;
      logic        ge;
      logic [5:0]  bit_mask;
      assign cmp      = {6'b0, div_reg[gi-1]} << SH;
      assign ge       = rem_reg[gi-1] >= cmp;
      assign bit_mask = 6'b1 << SH;

      // Restoring step: subtract the shifted divisor if it fits, and set
      // this stage's quotient bit.
      always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
          valid_reg[gi] <= 1'b0;
          rem_reg[gi]   <= '0;
          div_reg[gi]   <= '0;
          q_reg[gi]     <= '0;
          sign_reg[gi]  <= 1'b0;
          func_reg[gi]  <= '0;
        end else begin
          valid_reg[gi] <= valid_reg[gi-1];
          if (valid_reg[gi-1]) begin
            rem_reg[gi]  <= ge ? rem_reg[gi-1] - cmp : rem_reg[gi-1];
            q_reg[gi]    <= ge ? (q_reg[gi-1] | bit_mask) : q_reg[gi-1];
            div_reg[gi]  <= div_reg[gi-1];
            sign_reg[gi] <= sign_reg[gi-1];
            func_reg[gi] <= func_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  logic       valid7_reg;
  logic       grey7_reg;
  logic       sign7_reg;
  logic [1:0] func7_reg;
  logic [5:0] q7_reg;

  // Stage 7 clamps the quotient to 60 and decides whether the pixel is
  // achromatic. An achromatic pixel overrides any clamp.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      valid7_reg <= 1'b0;
      grey7_reg  <= 1'b0;
      sign7_reg  <= 1'b0;
      func7_reg  <= '0;
      q7_reg     <= '0;
    end else begin
      valid7_reg <= valid_reg[6];
      if (valid_reg[6]) begin
        q7_reg    <= (q_reg[6] > 6'd60) ? 6'd60 : q_reg[6];
        grey7_reg <= (div_reg[6] == 8'd0) || (func_reg[6] == 2'd0);
        sign7_reg <= sign_reg[6];
        func7_reg <= func_reg[6];
      end
    end
  end

  logic signed [9:0] sq;
  logic        [9:0] hue_next;

  // Map the signed sector offset onto the dominant channel's base angle.
  // Red wraps negative offsets up by 360. Negative zero stays at 0.
  always_comb begin
    sq       = sign7_reg ? -$signed({4'b0, q7_reg}) : $signed({4'b0, q7_reg});
    hue_next = '0;
    if (!grey7_reg) begin
      case (func7_reg)
        2'd1:    hue_next = sq[9] ? 10'(sq + 10'sd360) : 10'(sq);
        2'd2:    hue_next = 10'(sq + 10'sd120);
        2'd3:    hue_next = 10'(sq + 10'sd240);
        default: hue_next = '0;
      endcase
    end
  end

  // Output register. The data outputs hold their value across bubbles.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_valid <= 1'b0;
      o_hue   <= '0;
      o_grey  <= 1'b0;
    end else begin
      o_valid <= valid7_reg;
      if (valid7_reg) begin
        o_hue  <= HUE_W'(hue_next);
        o_grey <= grey7_reg;
      end
    end
  end

endmodule

// File: tb/tb_hue_calc.sv
// Testbench for hue_calc. Inputs are driven with a scoreboard queue of
// expected results. The o_valid pattern is checked every cycle against an
// edge-indexed table of expected pulses.
module tb_hue_calc;

  logic       clk = 1'b0;
  logic       rstn;
  logic [8:0] dividend;
  logic [8:0] divisor;
  logic [1:0] func;
  logic       valid;
  logic [8:0] hue;
  logic       grey;
  logic       ovalid;

  typedef struct {
    logic [8:0] hue;
    logic       grey;
  } exp_t;

  exp_t sb[$];
  bit   exp_v    [0:4095];
  bit   rst_edge [0:4095];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  bit   done_seen = 1'b0;

  hue_calc #(.HUE_W(9)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_dividend(dividend), .i_divisor(divisor),
    .i_function(func), .i_valid(valid), .o_hue(hue), .o_grey(grey),
    .o_valid(ovalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model that works from the arithmetic definition of hue.
  function automatic exp_t model(input int dd, input int dv, input int f);
    exp_t e;
    int mag, q, sq, h;
    e.grey = 1'b0;
    h = 0;
    if (dv == 0 || f == 0) begin
      e.grey = 1'b1;
    end else begin
      mag = (dd < 0) ? -dd : dd;
      q = (mag * 60) / dv;
      if (q > 60) q = 60;
      sq = (dd < 0) ? -q : q;
      case (f)
        1: h = (sq < 0) ? sq + 360 : sq;
        2: h = 120 + sq;
        default: h = 240 + sq;
      endcase
    end
    e.hue = 9'(h);
    return e;
  endfunction

  // Drive one cycle of input. A valid pixel is expected on the outputs after
  // the capturing edge plus 8.
  task automatic step(input bit v, input int dd, input int dv, input int f,
                      input int eh, input bit eg);
    exp_t e;
    valid    = v;
    dividend = 9'(dd);
    divisor  = 9'(dv);
    func     = 2'(f);
    if (v) begin
      e.hue  = 9'(eh);
      e.grey = eg;
      sb.push_back(e);
      exp_v[cyc + 9] = 1'b1;
    end
    @(negedge clk); #1;
  endtask

  task automatic step_model(input bit v, input int dd, input int dv, input int f);
    exp_t e;
    e = model(dd, dv, f);
    step(v, dd, dv, f, int'(e.hue), e.grey);
  endtask

  // Apply reset for one edge. All pixels in flight are dropped.
  task automatic pulse_reset();
    rstn  = 1'b0;
    valid = 1'b1;
    for (int i = 1; i <= 20; i++) exp_v[cyc + i] = 1'b0;
    sb.delete();
    rst_edge[cyc + 1] = 1'b1;
    @(negedge clk); #1;
    rstn = 1'b1;
  endtask

  // Monitor and scoreboard. Samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1 && !done_seen) begin
      checks++;
      assert (ovalid === exp_v[cyc]) else begin
        errors++;
        $error("FAIL valid_pattern cyc=%0d observed=%b expected=%b", cyc, ovalid, exp_v[cyc]);
      end
      if (rst_edge[cyc]) begin
        checks++;
        assert (hue === 9'd0 && grey === 1'b0) else begin
          errors++;
          $error("FAIL reset_state cyc=%0d observed hue=%0d grey=%b expected hue=0 grey=0", cyc, hue, grey);
        end
      end
      if (ovalid === 1'b1) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_output cyc=%0d observed hue=%0d expected none", cyc, hue);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          assert (hue === e.hue) else begin
            errors++;
            $error("FAIL hue cyc=%0d observed=%0d expected=%0d", cyc, hue, e.hue);
          end
          checks++;
          assert (grey === e.grey) else begin
            errors++;
            $error("FAIL grey cyc=%0d observed=%b expected=%b", cyc, grey, e.grey);
          end
        end
      end
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      checks++;
      assert (sb.size() == 0) else begin
        errors++;
        $error("FAIL missing_outputs observed_pending=%0d expected=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // Directed and random stimulus.
  initial begin
    rstn = 1'b0; valid = 1'b0; dividend = '0; divisor = '0; func = '0;
    rst_edge[1] = 1'b1;
    rst_edge[2] = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rstn = 1'b1;

    // Pure red, followed by a bubble so the pulse is a single cycle.
    step(1, 0, 248, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Magenta and yellow.
    step(1, -248, 248, 1, 300, 0);
    step(1, -248, 252, 2, 61, 0);
    // Blue and cyan boundary.
    step(1, 100, 200, 3, 270, 0);
    step(1, -252, 252, 2, 60, 0);
    // Grey and no-function cases. Divisor 0 also forces the clamp, and grey wins.
    step(1, 100, 0, 1, 0, 1);
    step(1, 50, 100, 0, 0, 1);
    // Negative zero on red stays 0. An out-of-range quotient clamps to 60.
    step(1, -1, 252, 1, 0, 0);
    step(1, 200, 100, 1, 60, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);

    // Streaming: 64 random legal pixels with random gaps.
    for (int n = 0; n < 64; ) begin
      int dv, dd, f;
      bit v;
      v  = ($urandom_range(0, 3) != 0);
      dv = int'($urandom_range(0, 252));
      dd = int'($urandom_range(0, dv));
      if ($urandom_range(0, 1) == 1) dd = -dd;
      f  = int'($urandom_range(0, 3));
      step_model(v, dd, dv, f);
      if (v) n++;
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);

    // Reset while 5 pixels are in flight. None of them may come out.
    for (int i = 0; i < 5; i++) step_model(1, 30 * i, 200, 1 + (i % 3));
    pulse_reset();
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0);
    step(1, -100, 200, 3, 210, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0);

    done = 1'b1;
  end

  // Upper bound on run time.
  initial begin
    #100000;
    $display("FAIL timeout observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hue_calc.md
# hue_calc

Pipelined hue back-end that sits directly downstream of `hsv_decoder` and replaces the divider-generator IP on that path. It takes the decoder's signed dividend, unsigned divisor and function code, and computes a hue angle in whole degrees (0..359) with a fixed-latency restoring division. It accepts one pixel per clock with no backpressure, matching the decoder's free-running `o_valid`.

## Interface
Parameters:
- `HUE_W`, default 9: hue output width; must be 9 or more to hold 359.

Ports:
- `i_clk`, in, 1: clock.
- `i_rstn`, in, 1: reset; synchronous, active-low.
- `i_dividend`, in, 9: signed two's-complement numerator; range -252..252.
- `i_divisor`, in, 9: unsigned denominator; bit 8 is always 0, range 0..252.
- `i_function`, in, 2: dominant channel. 1 = red, 2 = green, 3 = blue, 0 = none.
- `i_valid`, in, 1: input qualifier. Inputs are sampled only when it is 1.
- `o_hue`, out, `HUE_W`: hue in degrees, 0..359.
- `o_grey`, out, 1: the pixel is achromatic; `o_hue` is forced to 0.
- `o_valid`, out, 1: output qualifier; one pulse per accepted input.

## Operation
- **Stage 0 (input register).**
  - `sign = i_dividend[8]`.
  - `mag = |i_dividend|`, 8 bits.
  - `num = mag*60`, 14 bits, computed as `(mag<<6) - (mag<<2)`; no multiplier.
  - Register `num`, divisor (8 bits), sign, function and valid.
- **Stages 1..6 (restoring division), one quotient bit per stage, MSB first.**
  - Stage k handles quotient bit `6-k`.
  - If `rem >= (div << (6-k))`, then `rem -= div << (6-k)` and the bit is set.
  - Sign, function, divisor and valid travel alongside in shift registers.
  - Result: 6-bit floor quotient `q`.
- **Stage 7 (output register).**
  - `q` is clamped to 60 if it exceeds 60. The decoder guarantees `|dividend| <= divisor`, so this is defensive only.
  - If divisor is 0 or function is 0, then `o_hue = 0` and `o_grey = 1`.
  - Otherwise set `signed_q` to `+q` or `-q` according to sign, then:
    - function 1: `hue = signed_q`; if negative, add 360. Negative zero gives 0, never 360.
    - function 2: `hue = 120 + signed_q`, range 60..180.
    - function 3: `hue = 240 + signed_q`, range 180..300.
- **Valid-less cycles.**
  - A cycle with `i_valid = 0` enters the pipe as a bubble. `o_valid = 0` for that slot.
  - The data in a bubble slot is don't-care. Outputs are held, not zeroed: data registers update only when their stage's valid is 1.
- **Flow control.** None. Every valid input is accepted, the pipe never stalls, and occupancy can be 8 pixels.

## Timing
- Latency is exactly 8 cycles: input sampled at clock edge N gives `o_valid` / `o_hue` / `o_grey` after edge N+8.
- Throughput is 1 pixel/clock. Back-to-back inputs give back-to-back outputs, in order, with no gaps.
- **Reset values.** On a rising edge with `i_rstn = 0`:
  - all stage valid bits are 0;
  - `o_valid = 0`, `o_hue = 0`, `o_grey = 0`;
  - internal data registers are 0.
- **Reset mid-stream.** All in-flight pixels are discarded, with no partial output. The first input sampled after reset deasserts appears 8 cycles later.
- **Clamp and grey in the same cycle.** When a clamp and divisor = 0 coincide, grey wins.
- **Arithmetic widths.**
  - `num` is at most 252*60 = 15120, which fits in 14 bits.
  - The stage-1 comparand `div<<5` is at most 8064 and needs 13 bits.
  - The remainder is carried at 14 bits.
  - The hue pre-wrap value fits in signed 10 bits.

## Test plan
- Pure red: dividend 0, divisor 248, function 1 → 8 cycles later `o_hue = 0`, `o_grey = 0`, `o_valid` a single-cycle pulse.
- Magenta and yellow:
  - dividend -248 (9'h108), divisor 248, function 1 → `o_hue = 300`.
  - dividend -248, divisor 252, function 2 → `o_hue = 61` (14880/252 floors to 59).
- Blue and cyan boundary:
  - dividend 100, divisor 200, function 3 → `o_hue = 270`.
  - dividend -252, divisor 252, function 2 → `o_hue = 60`.
- Grey and no-function:
  - divisor 0, any dividend, function 1 → `o_hue = 0`, `o_grey = 1`.
  - function 0 with `i_valid = 1` → `o_hue = 0`, `o_grey = 1`.
- Streaming: 64 random legal inputs back-to-back with random `i_valid` gaps. Outputs must match a software model bit-exactly, in order, with the `o_valid` pattern equal to the `i_valid` pattern delayed 8 cycles.
- Reset mid-operation: drive 5 valid inputs, assert `i_rstn = 0` for 1 cycle, release. Outputs for those 5 must never appear, and `o_valid` stays 0 until 8 cycles after the next valid input.
